// File: rtl/pkg_testbench_defs.sv
// Shared types for the ALU dispatch path: request record, flag layout, dispatcher FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pkg_testbench_defs;

    localparam int DATA_SIZE = 8;

    typedef struct packed {
        logic aux_carry;
        logic neg;
        logic zero;
        logic carry;
    } alu_flags_t;

    typedef struct packed {
        logic [7:0]           op;
        logic [DATA_SIZE-1:0] oper_a;
        logic [DATA_SIZE-1:0] oper_b;
        logic                 use_flags;
        alu_flags_t           flags;
    } alu_req_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } dispatch_state_t;

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO of alu_req_t entries, FIFO_DEPTH deep, no write-to-read bypass.
// Latency: an entry pushed at one edge is visible at the head after that edge.
// Backpressure: pushes are dropped while full; pops are ignored while empty.
module alu_req_fifo
    import pkg_testbench_defs::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     push,
    input  alu_req_t push_dat,
    input  logic     pop,
    output alu_req_t pop_dat,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    alu_req_t    mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra MSB on each pointer distinguishes full from empty when the low bits match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/alu_op_dispatcher.sv
// Queues ALU requests, issues one at a time, captures result+flags after ALU_LATENCY edges.
// Latency: accept to rsp_valid = ALU_LATENCY+1 edges; optional counters via ALU_OP_DISPATCHER_STATS_EN.
// Backpressure: req_ready low when FIFO full or in reset; rsp_* held until rsp_ready.
module alu_op_dispatcher
    import pkg_testbench_defs::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_op,
    input  logic [DATA_SIZE-1:0] req_oper_a,
    input  logic [DATA_SIZE-1:0] req_oper_b,
    input  logic                 req_use_flags,
    input  logic [3:0]           req_flags,
    output logic [7:0]           alu_op,
    output logic [DATA_SIZE-1:0] alu_oper_a,
    output logic [DATA_SIZE-1:0] alu_oper_b,
    output logic [3:0]           alu_flags_in,
    input  logic [DATA_SIZE-1:0] alu_result,
    input  logic [3:0]           alu_flags_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_SIZE-1:0] rsp_result,
    output logic [3:0]           rsp_flags,
    output logic [3:0]           flags_q,
    output logic                 busy
`ifdef ALU_OP_DISPATCHER_STATS_EN
    ,
    output logic [15:0]          op_count,
    output logic [15:0]          stall_count
`endif
);

    localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    dispatch_state_t state;
    dispatch_state_t state_nxt;
    logic [CW-1:0]   cnt;
    logic            issue;
    logic            capture;
    logic            rsp_take;
    logic            fifo_full;
    logic            fifo_empty;
    alu_req_t        req_dat;
    alu_req_t        head;

    assign req_dat   = {req_op, req_oper_a, req_oper_b, req_use_flags, req_flags};
    assign req_ready = !fifo_full && !reset;
    assign busy      = !fifo_empty || (state != IDLE);

    alu_req_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (req_valid && req_ready),
        .push_dat (req_dat),
        .pop      (issue),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A response handshake and the next issue share one edge so back-to-back ops lose no cycle.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        capture   = 1'b0;
        rsp_take  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    issue     = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_take = 1'b1;
                    if (!fifo_empty) begin
                        issue     = 1'b1;
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_op       <= '0;
            alu_oper_a   <= '0;
            alu_oper_b   <= '0;
            alu_flags_in <= '0;
            cnt          <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            flags_q      <= '0;
        end else begin
            if (issue) begin
                alu_op       <= head.op;
                alu_oper_a   <= head.oper_a;
                alu_oper_b   <= head.oper_b;
                alu_flags_in <= head.use_flags ? flags_q : head.flags;
                cnt          <= CNT_INIT;
            end else if ((state == EXEC) && (cnt != '0)) begin
                cnt <= cnt - CNT_ONE;
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags_out;
                flags_q    <= alu_flags_out;
                rsp_valid  <= 1'b1;
            end else if (rsp_take) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_OP_DISPATCHER_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_count    <= '0;
            stall_count <= '0;
        end else begin
            if (rsp_take) begin
                op_count <= op_count + 16'd1;
            end
            if (req_valid && !req_ready && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Directed bench: single-op vector table, backpressure fill/drain, mid-op reset,
// and a second instance with ALU_LATENCY=3 for sample-edge timing.
module tb_alu_op_dispatcher;
    import pkg_testbench_defs::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       req_valid = 1'b0, req_valid3 = 1'b0;
    logic       rsp_ready = 1'b0, rsp_ready3 = 1'b0;
    logic [7:0] req_op = '0, req_oper_a = '0, req_oper_b = '0;
    logic       req_use_flags = 1'b0;
    logic [3:0] req_flags = '0;

    logic       req_ready, rsp_valid, busy;
    logic [7:0] alu_op, alu_oper_a, alu_oper_b, alu_result, rsp_result;
    logic [3:0] alu_flags_in, alu_flags_out, rsp_flags, flags_q;

    logic       req_ready3, rsp_valid3, busy3;
    logic [7:0] alu_op3, alu_oper_a3, alu_oper_b3, rsp_result3;
    logic [7:0] alu3_res = '0;
    logic [3:0] alu3_flg = '0;
    logic [3:0] alu_flags_in3, rsp_flags3, flags_q3;

`ifdef ALU_OP_DISPATCHER_STATS_EN
    logic [15:0] op_count, stall_count, op_count3, stall_count3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_op_dispatcher #(.FIFO_DEPTH(4), .ALU_LATENCY(1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_oper_a(req_oper_a), .req_oper_b(req_oper_b),
        .req_use_flags(req_use_flags), .req_flags(req_flags),
        .alu_op(alu_op), .alu_oper_a(alu_oper_a), .alu_oper_b(alu_oper_b),
        .alu_flags_in(alu_flags_in), .alu_result(alu_result), .alu_flags_out(alu_flags_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .flags_q(flags_q), .busy(busy)
`ifdef ALU_OP_DISPATCHER_STATS_EN
        , .op_count(op_count), .stall_count(stall_count)
`endif
    );

    alu_op_dispatcher #(.FIFO_DEPTH(4), .ALU_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op),
        .req_oper_a(req_oper_a), .req_oper_b(req_oper_b),
        .req_use_flags(req_use_flags), .req_flags(req_flags),
        .alu_op(alu_op3), .alu_oper_a(alu_oper_a3), .alu_oper_b(alu_oper_b3),
        .alu_flags_in(alu_flags_in3), .alu_result(alu3_res), .alu_flags_out(alu3_flg),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
        .rsp_flags(rsp_flags3), .flags_q(flags_q3), .busy(busy3)
`ifdef ALU_OP_DISPATCHER_STATS_EN
        , .op_count(op_count3), .stall_count(stall_count3)
`endif
    );

    // ALU stand-in: a + b + carry_in; flags {aux_carry=0, neg, zero, carry}.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum       = {1'b0, alu_oper_a} + {1'b0, alu_oper_b} + {8'd0, alu_flags_in[0]};
        alu_result    = alu_sum[7:0];
        alu_flags_out = {1'b0, alu_sum[7], (alu_sum[7:0] == 8'd0), alu_sum[8]};
    end

    typedef struct {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_flags;
        logic [3:0] flags;
        logic [3:0] exp_fin;
        logic [7:0] exp_res;
        logic [3:0] exp_flags;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic uf, input logic [3:0] fl);
        req_op = op; req_oper_a = a; req_oper_b = b; req_use_flags = uf; req_flags = fl;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        // Results chain through flags_q, so order matters.
        vecs[0] = '{8'h01, 8'hFF, 8'h01, 1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0011};
        vecs[1] = '{8'h01, 8'h10, 8'h20, 1'b1, 4'b0000, 4'b0011, 8'h31, 4'b0000};
        vecs[2] = '{8'h02, 8'h7F, 8'h00, 1'b0, 4'b0001, 4'b0001, 8'h80, 4'b0100};
        vecs[3] = '{8'h03, 8'h80, 8'h80, 1'b1, 4'b0000, 4'b0100, 8'h00, 4'b0011};
        vecs[4] = '{8'h04, 8'h01, 8'h01, 1'b1, 4'b1000, 4'b0011, 8'h03, 4'b0000};
        vecs[5] = '{8'h05, 8'hF0, 8'h0F, 1'b0, 4'b1111, 4'b1111, 8'h00, 4'b0011};
        vecs[6] = '{8'h06, 8'hC0, 8'h30, 1'b1, 4'b0000, 4'b0011, 8'hF1, 4'b0100};

        // Reset state
        #1;
        check("rst_req_ready", req_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_req_ready_after", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_flags_q", flags_q, 0);
        check("rst_alu_oper_a", alu_oper_a, 0);
        check("rst_rsp_result", rsp_result, 0);

        // Single ops, exact-cycle timing: accept, issue, capture, handshake.
        rsp_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            set_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_flags, vecs[i].flags);
            req_valid = 1'b1;
            check($sformatf("v%0d_req_ready", i), req_ready, 1);
            tick();
            req_valid = 1'b0;
            check($sformatf("v%0d_busy_queued", i), busy, 1);
            check($sformatf("v%0d_no_early_rsp", i), rsp_valid, 0);
            tick();
            check($sformatf("v%0d_alu_op", i), alu_op, vecs[i].op);
            check($sformatf("v%0d_alu_oper_a", i), alu_oper_a, vecs[i].a);
            check($sformatf("v%0d_alu_oper_b", i), alu_oper_b, vecs[i].b);
            check($sformatf("v%0d_alu_flags_in", i), alu_flags_in, vecs[i].exp_fin);
            check($sformatf("v%0d_rsp_valid_lo", i), rsp_valid, 0);
            tick();
            check($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
            check($sformatf("v%0d_rsp_result", i), rsp_result, vecs[i].exp_res);
            check($sformatf("v%0d_rsp_flags", i), rsp_flags, vecs[i].exp_flags);
            check($sformatf("v%0d_flags_q", i), flags_q, vecs[i].exp_flags);
            tick();
            check($sformatf("v%0d_rsp_done", i), rsp_valid, 0);
            check($sformatf("v%0d_idle", i), busy, 0);
        end

        // Backpressure: 5 pushes with rsp_ready low fill FIFO behind the held response.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(8'h10, 8'(i * 16 + 1), 8'(i), 1'b0, 4'b0000);
            req_valid = 1'b1;
            check($sformatf("bp_req_ready_%0d", i), req_ready, 1);
            tick();
        end
        req_valid = 1'b1;
        check("bp_full_req_ready", req_ready, 0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_hold_valid_%0d", i), rsp_valid, 1);
            check($sformatf("bp_hold_result_%0d", i), rsp_result, 8'h01);
            tick();
        end
        begin
            logic [7:0] exp_bp [5];
            int got_cyc [5];
            logic [7:0] got_res [5];
            int n_got = 0;
            exp_bp[0] = 8'h01; exp_bp[1] = 8'h12; exp_bp[2] = 8'h23;
            exp_bp[3] = 8'h34; exp_bp[4] = 8'h45;
            rsp_ready = 1'b1;
            for (int c = 0; c < 40; c++) begin
                if (rsp_valid && n_got < 5) begin
                    got_res[n_got] = rsp_result;
                    got_cyc[n_got] = c;
                    n_got++;
                end
                tick();
            end
            check("bp_resp_count", n_got, 5);
            for (int i = 0; i < n_got && i < 5; i++) begin
                check($sformatf("bp_order_%0d", i), got_res[i], exp_bp[i]);
                if (i > 0) check($sformatf("bp_spacing_%0d", i), got_cyc[i] - got_cyc[i-1], 2);
            end
            check("bp_drained_busy", busy, 0);
        end

        // Reset while in EXEC with two entries queued.
        rsp_ready = 1'b0;
        set_req(8'h20, 8'hFF, 8'h01, 1'b0, 4'b0000);
        req_valid = 1'b1;
        tick();
        set_req(8'h21, 8'h02, 8'h03, 1'b0, 4'b0000);
        tick();
        set_req(8'h22, 8'h04, 8'h05, 1'b0, 4'b0000);
        tick();
        check("rr_flags_q_before", flags_q, 4'b0011);
        rsp_ready = 1'b1;
        set_req(8'h23, 8'h06, 8'h07, 1'b0, 4'b0000);
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("rr_in_exec", rsp_valid, 0);
        check("rr_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("rr_req_ready_in_reset", req_ready, 0);
        check("rr_flags_q_cleared", flags_q, 0);
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("rr_req_ready_after", req_ready, 1);
        begin
            int seen = 0;
            for (int c = 0; c < 6; c++) begin
                tick();
                if (rsp_valid) seen++;
            end
            check("rr_no_response", seen, 0);
        end
        check("rr_busy_after", busy, 0);
        check("rr_flags_q_after", flags_q, 0);

        // ALU_LATENCY=3: only the bus value at the 3rd edge after issue is captured.
        rsp_ready3 = 1'b0;
        set_req(8'h30, 8'h05, 8'h06, 1'b0, 4'b0000);
        req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        alu3_res = 8'h11; alu3_flg = 4'b1111;
        check("l3_no_rsp_e0", rsp_valid3, 0);
        tick();
        check("l3_issue_oper_a", alu_oper_a3, 8'h05);
        check("l3_no_rsp_e1", rsp_valid3, 0);
        alu3_res = 8'h22;
        tick();
        check("l3_no_rsp_e2", rsp_valid3, 0);
        alu3_res = 8'h23;
        tick();
        check("l3_no_rsp_e3", rsp_valid3, 0);
        alu3_res = 8'h33; alu3_flg = 4'b0101;
        tick();
        check("l3_rsp_valid_e4", rsp_valid3, 1);
        check("l3_rsp_result", rsp_result3, 8'h33);
        check("l3_rsp_flags", rsp_flags3, 4'b0101);
        check("l3_flags_q", flags_q3, 4'b0101);
        alu3_res = 8'h44; alu3_flg = 4'b0000;
        tick();
        check("l3_hold_result", rsp_result3, 8'h33);
        rsp_ready3 = 1'b1;
        tick();
        check("l3_rsp_done", rsp_valid3, 0);
        check("l3_idle", busy3, 0);

`ifdef ALU_OP_DISPATCHER_STATS_EN
        pulse_reset();
        check("st_op_count_rst", op_count, 0);
        check("st_stall_count_rst", stall_count, 0);
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(8'h40, 8'(i), 8'h01, 1'b0, 4'b0000);
            req_valid = 1'b1;
            tick();
        end
        for (int i = 0; i < 3; i++) tick();
        req_valid = 1'b0;
        check("st_stall_count", stall_count, 3);
        rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        check("st_op_count", op_count, 5);
        check("st_stall_count_held", stall_count, 3);
`else
        pulse_reset();
        check("end_idle", busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_dispatcher.md
Name: alu_op_dispatcher

Overview:
- Upstream stage of the ALU. Accepts operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Issues one operation at a time onto the ALU input bus, waits a fixed ALU latency, then captures result and flags.
- Holds an architectural flag register so chained ops can consume the previous op's flags; returns results over a valid/ready response port.

Parameters:
DATA_SIZE, 8 (from pkg_testbench_defs), operand/result width
FIFO_DEPTH, 4, request FIFO entries, power of two, >=2
ALU_LATENCY, 1, edges from ALU input drive to result sample, >=1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&&req_ready at posedge
req_op  in  8  ALU opcode
req_oper_a  in  DATA_SIZE  operand A
req_oper_b  in  DATA_SIZE  operand B
req_use_flags  in  1  1: feed flags_q to ALU; 0: feed req_flags
req_flags  in  4  explicit input flags {aux_carry,neg,zero,carry}
alu_op  out  8  registered opcode to ALU
alu_oper_a  out  DATA_SIZE  registered operand A
alu_oper_b  out  DATA_SIZE  registered operand B
alu_flags_in  out  4  registered input flags {aux_carry,neg,zero,carry}
alu_result  in  DATA_SIZE  ALU result
alu_flags_out  in  4  ALU output flags {aux_carry,neg,zero,carry}
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready at posedge
rsp_result  out  DATA_SIZE  captured result
rsp_flags  out  4  captured output flags
flags_q  out  4  architectural flag register
busy  out  1  FIFO non-empty or state!=IDLE

Behaviour:
- Reset (async, active-high): FIFO empty; state IDLE; every registered output (alu_*, rsp_*, flags_q) 0. req_ready forced 0 while reset is high. Reset mid-operation discards the in-flight op and all queued entries; no response is produced.
- req_ready = !fifo_full && !reset. A push is refused when full, even if a pop happens in the same cycle. There is no bypass: an entry pushed at edge A is popped no earlier than edge A+1.
- FSM states IDLE, EXEC, RESP:
  - IDLE: if FIFO non-empty at edge E, pop the head and register alu_op/alu_oper_a/alu_oper_b. alu_flags_in <= req_use_flags ? flags_q : req_flags. cnt <= ALU_LATENCY-1. Go to EXEC.
  - EXEC: if cnt==0, sample alu_result/alu_flags_out into rsp_result/rsp_flags, set flags_q <= alu_flags_out, set rsp_valid <= 1, go to RESP. Otherwise cnt--. The sample edge is E+ALU_LATENCY.
  - RESP: hold rsp_* stable until the handshake. On rsp_valid&&rsp_ready: rsp_valid <= 0. If the FIFO is non-empty, pop and issue in the same edge (IDLE actions) and go to EXEC; otherwise go to IDLE.
- alu_* outputs hold their last value between ops.
- Latency from accept edge to rsp_valid high: ALU_LATENCY+1 edges with an empty pipeline.
- Sustained throughput with rsp_ready=1: one op per ALU_LATENCY+1 cycles.
- Ops are serialised, so flags_q at issue time always includes the previous op's flags.
- The FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the low bits are equal.

Optional Feature:
- ALU_OP_DISPATCHER_STATS_EN defined: adds output op_count[15:0], which increments on each response handshake, wraps 0xFFFF->0x0000, and resets to 0. Also adds stall_count[15:0], which increments each cycle req_valid&&!req_ready, saturates at 0xFFFF, and resets to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- pkg_testbench_defs gets:
  - DATA_SIZE, already present.
  - alu_flags_t, a packed struct {aux_carry,neg,zero,carry}.
  - alu_req_t, a packed struct {op,oper_a,oper_b,use_flags,flags}.
  - dispatch_state_t enum {IDLE,EXEC,RESP}.
- One sub-module: alu_req_fifo, a synchronous FIFO of alu_req_t parameterised by FIFO_DEPTH, with full/empty flags and async active-high reset.

Test Plan:
- The bench ALU model adds a+b with carry, ALU_LATENCY=1, DATA_SIZE=8.
- Reset then a single request op=0x01, a=0xFF, b=0x01, use_flags=0, flags=0 accepted at edge 0 -> alu_oper_a=0xFF at edge 1; rsp_valid at edge 2 with result 0x00, flags 4'b0011; flags_q=4'b0011.
- Chained request with use_flags=1 following that op -> alu_flags_in=4'b0011 on issue; a=0x10, b=0x20 gives result 0x31 with carry-in.
- rsp_ready=0 while pushing 5 requests -> req_ready drops after the FIFO fills (4 queued + 1 in RESP hold); rsp_* remain stable. Release rsp_ready -> all 5 responses arrive in order, one every 2 cycles.
- Assert reset for 1 cycle while in EXEC with 2 queued -> no rsp_valid afterwards, flags_q=0, busy=0, req_ready=1 after reset drops.
- ALU_LATENCY=3 build -> rsp_valid exactly 4 edges after accept; ALU result sampled only at the 3rd edge after issue, so changes earlier are ignored.
- STATS build: 0xFFFF completed ops then 1 more -> op_count wraps to 0x0000; a 3-cycle refused push -> stall_count=3.
